// File: rtl/uart_tx.sv
// UART serial transmitter: start bit, DBIT data bits LSB first, SB_TICK/16 stop bits,
// all timed from a shared 16x-oversampled baud tick.
module uart_tx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic       s_tick,
  input  logic [7:0] din,
  output logic       tx_done_tick,
  output logic       busy,
  output logic       tx
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [4:0] BIT_LAST  = 5'd15;
  localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
  localparam logic [2:0] DATA_LAST = 3'(DBIT - 1);

  state_t     state_r;
  logic [4:0] s_r;
  logic [2:0] n_r;
  logic [7:0] b_r;
  logic       tx_r;

  // Frame sequencer; tx is driven from a register so the line never glitches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      s_r     <= 5'd0;
      n_r     <= 3'd0;
      b_r     <= 8'd0;
      tx_r    <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          tx_r <= 1'b1;
          if (tx_start) begin
            b_r     <= din;
            s_r     <= 5'd0;
            state_r <= START;
            tx_r    <= 1'b0;
          end
        end
        START: begin
          tx_r <= 1'b0;
          if (s_tick) begin
            if (s_r == BIT_LAST) begin
              s_r     <= 5'd0;
              n_r     <= 3'd0;
              state_r <= DATA;
              tx_r    <= b_r[0];
            end else begin
              s_r <= s_r + 5'd1;
            end
          end
        end
        DATA: begin
          tx_r <= b_r[0];
          if (s_tick) begin
            if (s_r == BIT_LAST) begin
              s_r <= 5'd0;
              b_r <= {1'b0, b_r[7:1]};
              // Load the next line value together with the shift so tx changes on this edge.
              if (n_r == DATA_LAST) begin
                state_r <= STOP;
                tx_r    <= 1'b1;
              end else begin
                n_r  <= n_r + 3'd1;
                tx_r <= b_r[1];
              end
            end else begin
              s_r <= s_r + 5'd1;
            end
          end
        end
        STOP: begin
          tx_r <= 1'b1;
          if (s_tick) begin
            if (s_r == STOP_LAST) begin
              state_r <= IDLE;
            end else begin
              s_r <= s_r + 5'd1;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          tx_r    <= 1'b1;
        end
      endcase
    end
  end

  assign tx_done_tick = (state_r == STOP) && s_tick && (s_r == STOP_LAST);
  assign busy         = (state_r != IDLE);
  assign tx           = tx_r;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: a tick-counting line receiver decodes frames and
// compares them against bytes queued at accept time; a second instance covers DBIT=7/SB_TICK=32.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       reset, tx_start, s_tick, tx_done_tick, busy, tx;
  logic [7:0] din;
  logic       tx_start2, s_tick2, done2, busy2, tx2;
  logic [7:0] din2;

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         done_cnt = 0;
  int         frames = 0;
  int         div = 16;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  uart_tx #(.DBIT(8), .SB_TICK(16)) dut (
    .clk(clk), .reset(reset), .tx_start(tx_start), .s_tick(s_tick), .din(din),
    .tx_done_tick(tx_done_tick), .busy(busy), .tx(tx)
  );

  uart_tx #(.DBIT(7), .SB_TICK(32)) dut2 (
    .clk(clk), .reset(reset), .tx_start(tx_start2), .s_tick(s_tick2), .din(din2),
    .tx_done_tick(done2), .busy(busy2), .tx(tx2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Baud tick: one clk wide every div clocks, changed on the falling edge.
  initial begin
    int ph;
    ph = 0;
    s_tick = 1'b0;
    forever begin
      @(negedge clk);
      ph++;
      s_tick = (ph % div == 0) ? 1'b1 : 1'b0;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (tx_done_tick === 1'b1) done_cnt++;
    end
  end

  // Line receiver: hunts for a low line, samples mid-bit by counting s_tick.
  initial begin
    int st, cnt;
    logic [7:0] sh;
    st = 0; cnt = 0; sh = 8'd0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        st = 0;
      end else if (st == 0) begin
        if (tx === 1'b0) begin
          st = 1; cnt = 0; sh = 8'd0;
        end
      end else if (s_tick === 1'b1) begin
        cnt++;
        if (cnt == 8) begin
          check_eq("rx_start_bit", 32'(tx), 32'd0);
        end else if (cnt > 8 && cnt % 16 == 8) begin
          if (cnt < 8 + 16 * 9) begin
            sh = {tx, sh[7:1]};
          end else begin
            check_eq("rx_stop_bit", 32'(tx), 32'd1);
            if (exp_q.size() == 0) check_eq("rx_spurious_frame", 32'd1, 32'd0);
            else check_eq("rx_byte", 32'(sh), 32'(exp_q.pop_front()));
            st = 0;
          end
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input bit align, input bit completes, output int acc);
    if (align) begin
      do begin
        @(negedge clk);
        #2;
      end while (s_tick !== 1'b1);
    end else begin
      @(negedge clk);
      #2;
    end
    din = d;
    tx_start = 1'b1;
    if (completes) begin
      exp_q.push_back(d);
      frames++;
    end
    @(posedge clk);
    #1;
    acc = cyc;
    tx_start = 1'b0;
    check_eq("accept_tx_low", 32'(tx), 32'd0);
    check_eq("accept_busy", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(input int budget, output int dcyc, output bit busy_ok);
    bit found;
    found = 1'b0;
    busy_ok = 1'b1;
    dcyc = 0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (tx_done_tick === 1'b1) begin
        found = 1'b1;
        dcyc = cyc + 1;
      end
    end
    check_eq("done_seen", 32'(found), 32'd1);
    #2;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2, dc, k, d2at, d2cnt;
    bit bok;
    logic [7:0] lb[3];
    logic [7:0] v2;
    logic       e2;
    lb = '{8'h00, 8'hFF, 8'h3C};
    reset = 1'b1; tx_start = 1'b0; din = 8'h00;
    tx_start2 = 1'b0; din2 = 8'h00; s_tick2 = 1'b1;
    #1;
    check_eq("reset_tx", 32'(tx), 32'd1);
    check_eq("reset_busy", 32'(busy), 32'd0);
    check_eq("reset_done", 32'(tx_done_tick), 32'd0);
    check_eq("reset_tx2", 32'(tx2), 32'd1);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Basic 0xA5 frame, accepted on a tick edge so the frame is exactly 2560 clk.
    send(8'hA5, 1'b1, 1'b1, a1);
    wait_done(3000, dc, bok);
    check_eq("a5_length", 32'(dc - a1), 32'd2560);
    check_eq("a5_busy_held", 32'(bok), 32'd1);
    check_eq("a5_done_count", 32'(done_cnt), 32'(frames));
    @(posedge clk);
    #1;
    check_eq("a5_idle_busy", 32'(busy), 32'd0);
    check_eq("a5_idle_tx", 32'(tx), 32'd1);

    for (int i = 0; i < 3; i++) begin
      send(lb[i], 1'b0, 1'b1, a1);
      wait_done(3000, dc, bok);
      check_eq("loop_done_count", 32'(done_cnt), 32'(frames));
    end

    // Starts while busy: mid-data and in the done cycle, both ignored.
    send(8'h0F, 1'b1, 1'b1, a1);
    repeat (800) @(negedge clk);
    #2;
    din = 8'h55;
    tx_start = 1'b1;
    @(negedge clk);
    #2;
    tx_start = 1'b0;
    wait_done(3000, dc, bok);
    din = 8'h55;
    tx_start = 1'b1;
    @(posedge clk);
    #1;
    tx_start = 1'b0;
    check_eq("busy_start_idle", 32'(busy), 32'd0);
    check_eq("busy_start_tx", 32'(tx), 32'd1);
    repeat (300) @(negedge clk);
    #2;
    check_eq("busy_start_quiet_tx", 32'(tx), 32'd1);
    check_eq("busy_start_quiet_busy", 32'(busy), 32'd0);
    check_eq("busy_start_done_count", 32'(done_cnt), 32'(frames));

    // Back-to-back: second start in the cycle right after the done pulse.
    send(8'h7E, 1'b1, 1'b1, a1);
    wait_done(3000, dc, bok);
    send(8'h81, 1'b0, 1'b1, a2);
    check_eq("b2b_gap", 32'(a2 - a1), 32'd2561);
    wait_done(3000, dc, bok);
    check_eq("b2b_done_count", 32'(done_cnt), 32'(frames));

    // Reset during data bit 3 of 0x00.
    send(8'h00, 1'b1, 1'b0, a1);
    repeat (1150) @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq("rst_mid_tx", 32'(tx), 32'd1);
    check_eq("rst_mid_busy", 32'(busy), 32'd0);
    check_eq("rst_mid_done", 32'(tx_done_tick), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_eq("rst_mid_no_done", 32'(done_cnt), 32'(frames));
    send(8'h96, 1'b1, 1'b1, a1);
    wait_done(3000, dc, bok);
    check_eq("rst_after_length", 32'(dc - a1), 32'd2560);

    // DBIT=7, SB_TICK=32, tick every clk, 0xC1.
    v2 = 8'hC1;
    @(negedge clk);
    #2;
    din2 = v2;
    tx_start2 = 1'b1;
    @(posedge clk);
    #1;
    tx_start2 = 1'b0;
    check_eq("p7_accept_tx", 32'(tx2), 32'd0);
    check_eq("p7_accept_busy", 32'(busy2), 32'd1);
    d2at = 0;
    d2cnt = 0;
    for (int i = 1; i <= 170; i++) begin
      @(posedge clk);
      #1;
      if (i % 16 == 8 && i <= 152) begin
        k = i / 16;
        e2 = (k == 0) ? 1'b0 : (k <= 7) ? v2[k-1] : 1'b1;
        check_eq($sformatf("p7_bit%0d", k), 32'(tx2), 32'(e2));
      end
      if (done2 === 1'b1) begin
        d2cnt++;
        if (d2at == 0) d2at = i + 1;
      end
      if (i == 160) begin
        check_eq("p7_idle_busy", 32'(busy2), 32'd0);
        check_eq("p7_idle_tx", 32'(tx2), 32'd1);
      end
    end
    check_eq("p7_length", 32'(d2at), 32'd160);
    check_eq("p7_done_pulses", 32'(d2cnt), 32'd1);

    repeat (20) @(negedge clk);
    check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
    check_eq("final_done_count", 32'(done_cnt), 32'(frames));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART serial transmitter that shifts a parallel byte out on a single line as start bit, DBIT data bits (LSB first) and stop bit(s). It pairs with the UART receiver in the UART subsystem and shares its 16x-oversampled baud tick (`s_tick`) from the common baud-rate generator. The host side (CPU/FIFO) presents a byte with a one-cycle start strobe and gets a one-cycle done pulse when the frame is complete.

## Interface
- `DBIT`, default 8: number of data bits per frame; legal 5..8; sends `din[DBIT-1:0]`.
- `SB_TICK`, default 16: stop-bit length in `s_tick` units; legal 16 (1 stop), 24 (1.5), 32 (2).
- `clk`  input  1  system clock; all state changes on its rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `tx_start`  input  1  start strobe; accepted only in idle.
- `s_tick`  input  1  baud tick at 16x bit rate, one `clk` wide.
- `din`  input  8  byte to transmit; sampled on the accepting edge.
- `tx_done_tick`  output  1  one-cycle pulse at end of stop bit.
- `busy`  output  1  high whenever state is not idle.
- `tx`  output  1  serial line, registered, idle high.

## Operation
- Internal registers: state (2 bits), tick counter `s` (5 bits), bit counter `n` (3 bits), shift register `b` (8 bits), output register `tx_reg`.
- Reset (async, any time incl. mid-frame): state=idle, s=0, n=0, b=0, `tx`=1, `busy`=0, `tx_done_tick`=0. No partial frame resumes after reset.
- idle: `tx_reg`=1. If `tx_start`=1: b<=din, s<=0, state<=start, `tx_reg`<=0. `s_tick` ignored.
- start: `tx_reg` held 0. On `s_tick`: if s==15 -> s<=0, n<=0, state<=data, `tx_reg`<=b[0]; else s<=s+1.
- data: `tx_reg` holds b[0]. On `s_tick`: if s==15 -> s<=0, b<=b>>1 (zero fill); if n==DBIT-1 -> state<=stop, `tx_reg`<=1; else n<=n+1, `tx_reg`<=next bit (b[1]); else s<=s+1.
- stop: `tx_reg` held 1. On `s_tick`: if s==SB_TICK-1 -> state<=idle; else s<=s+1.
- `tx_done_tick` is combinational: high exactly in the cycle where state==stop, `s_tick`==1, s==SB_TICK-1.
- `busy` = (state != idle), combinational from state register.
- `tx_start` while busy (including the `tx_done_tick` cycle) is ignored; no queuing. `din` changes while busy have no effect.
- Counter widths: s compares to 15 and SB_TICK-1 (max 31) without wrap; n never exceeds DBIT-1.

## Timing
- Accept edge: `tx` falls and `busy` rises on the same `clk` edge that samples `tx_start`=1 in idle.
- Start bit lasts 16 `s_tick`s (the first counted tick is the first one after the accept edge); each data bit 16 `s_tick`s; stop SB_TICK `s_tick`s.
- Frame length = 16*(1+DBIT) + SB_TICK ticks; defaults: 160 ticks.
- Bit transitions on `tx` occur on the `clk` edge following the 16th tick of the previous bit; `tx` is glitch-free (register output).
- Back-to-back: `tx_start` in the cycle after `tx_done_tick` is accepted; minimum idle gap between frames is one `clk`.
- `s_tick` asserted continuously (every `clk`) is legal; frame then takes exactly 160 clk cycles after accept edge at defaults.

## Test plan
- Basic frame: DBIT=8, SB_TICK=16, `s_tick` every 16 clk, `din`=0xA5 with one-cycle `tx_start` -> `tx` = 0, then 1,0,1,0,0,1,0,1, then 1, each bit 256 clk wide; `tx_done_tick` single pulse 2560 clk after accept; `busy` high throughout.
- Receiver loopback: connect `tx` to the UART receiver (same tick), send 0x00, 0xFF, 0x3C -> receiver `dout` matches each byte, one `rx_done_tick` per frame.
- Start while busy: pulse `tx_start` with `din`=0x55 mid-data of a 0x0F frame and again in the `tx_done_tick` cycle -> line carries only 0x0F, exactly one `tx_done_tick`; `tx` stays 1 afterwards.
- Back-to-back: `tx_start` with 0x81 in the cycle after `tx_done_tick` -> `tx` falls on that edge; two contiguous frames, stop bit exactly 16 ticks.
- Reset mid-frame: assert `reset` during data bit 3 of 0x00 -> `tx`=1, `busy`=0 immediately (before next clk edge); no `tx_done_tick`; next `tx_start` sends a full clean frame.
- Parameters: DBIT=7, SB_TICK=32, `s_tick` every clk, `din`=0xC1 -> 7 data bits 1,0,0,0,0,0,1 (bit 7 not sent), stop 32 clk, total 160 clk from accept to idle.
